// File: rtl/hangman_guess_engine_pkg.sv
// Shared types and constants for the Wireless Hangman guess engine.
// Pure declarations, no logic.
package hangman_pkg;

    localparam int WORD_LEN     = 5;
    localparam int CHAR_W       = 8;
    localparam int MAX_MISTAKES = 6;

    localparam logic [CHAR_W-1:0] ASCII_A = 8'h41;
    localparam logic [CHAR_W-1:0] ASCII_Z = 8'h5A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

endpackage

// File: rtl/hangman_guess_engine_if.sv
// Host-side bundle between the guess source, the engine and the LCD status consumer.
// The master drives word/guess; the slave (engine) answers with ready and status.
interface hangman_guess_engine_if;
    import hangman_pkg::*;

    logic [WORD_LEN*CHAR_W-1:0] word;
    logic                       word_valid;
    logic [CHAR_W-1:0]          guess;
    logic                       guess_valid;
    logic                       guess_ready;
    logic [WORD_LEN-1:0]        indexCorrect;
    logic [2:0]                 correct;
    logic                       mistake;
    logic [2:0]                 numMistake;
    logic [CHAR_W-1:0]          letter;
    logic                       repeat_guess;
    logic                       invalid;
    logic                       update;
    logic                       game_win;
    logic                       game_lose;

    modport master (
        output word, word_valid, guess, guess_valid,
        input  guess_ready, indexCorrect, correct, mistake, numMistake,
               letter, repeat_guess, invalid, update, game_win, game_lose
    );

    modport slave (
        input  word, word_valid, guess, guess_valid,
        output guess_ready, indexCorrect, correct, mistake, numMistake,
               letter, repeat_guess, invalid, update, game_win, game_lose
    );

endinterface

// File: rtl/hangman_guess_engine_matcher.sv
// Compares one guessed character against every byte of the word; zero latency.
// Bit 4 of the mask corresponds to the first character (word MSByte).
module letter_matcher
    import hangman_pkg::*;
(
    input  logic [CHAR_W-1:0]          guess_i,
    input  logic [WORD_LEN*CHAR_W-1:0] word_i,
    output logic [WORD_LEN-1:0]        mask_o,
    output logic [2:0]                 count_o
);

    always_comb begin
        mask_o  = '0;
        count_o = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            mask_o[i] = (word_i[i*CHAR_W +: CHAR_W] == guess_i);
            count_o   = count_o + 3'(mask_o[i]);
        end
    end

endmodule

// File: rtl/hangman_guess_engine.sv
// Hangman game core: one guess per handshake, results registered after one CHECK cycle
// (accept at edge k, status + update pulse after k+1). guess_ready is low outside PLAY.
module hangman_guess_engine
    import hangman_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRst,
    hangman_guess_engine_if.slave bus
);

    state_t                     state_q;
    logic [WORD_LEN*CHAR_W-1:0] word_q;
    logic [CHAR_W-1:0]          guess_q;
    logic [25:0]                guessed_q;
    logic [WORD_LEN-1:0]        index_q;
    logic [2:0]                 correct_q;
    logic                       mistake_q;
    logic [2:0]                 num_q;
    logic [CHAR_W-1:0]          letter_q;
    logic                       repeat_q;
    logic                       invalid_q;
    logic                       update_q;
    logic                       win_q;
    logic                       lose_q;

    logic [WORD_LEN-1:0] match_mask;
    logic [2:0]          match_cnt;

    letter_matcher u_match (
        .guess_i (guess_q),
        .word_i  (word_q),
        .mask_o  (match_mask),
        .count_o (match_cnt)
    );

    logic                letter_ok;
    logic                already;
    logic [4:0]          letter_idx;
    logic [31:0]         guessed_ext;
    logic [31:0]         set_vec;
    logic                hit;
    logic                miss;
    logic [WORD_LEN-1:0] index_d;
    logic [2:0]          num_d;
    logic [25:0]         guessed_d;

    // Outcome of the CHECK cycle, in rule priority: invalid, repeat, hit, miss.
    always_comb begin
        letter_ok   = (guess_q >= ASCII_A) && (guess_q <= ASCII_Z);
        letter_idx  = 5'(guess_q - ASCII_A);
        guessed_ext = {6'd0, guessed_q};
        set_vec     = 32'd1 << letter_idx;
        already     = letter_ok && guessed_ext[letter_idx];
        hit         = letter_ok && !already && (match_mask != '0);
        miss        = letter_ok && !already && (match_mask == '0);
        index_d     = index_q;
        num_d       = num_q;
        guessed_d   = guessed_q;
        if (letter_ok && !already) begin
            guessed_d = guessed_q | set_vec[25:0];
        end
        if (hit) begin
            index_d = index_q | match_mask;
        end
        if (miss && (num_q != 3'(MAX_MISTAKES))) begin
            num_d = num_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            guess_q   <= '0;
            guessed_q <= '0;
            index_q   <= '0;
            correct_q <= '0;
            mistake_q <= 1'b0;
            num_q     <= '0;
            letter_q  <= '0;
            repeat_q  <= 1'b0;
            invalid_q <= 1'b0;
            update_q  <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else if (bus.word_valid) begin
            // A new word overrides any state, including a pending CHECK or offered guess.
            state_q   <= PLAY;
            word_q    <= bus.word;
            guessed_q <= '0;
            index_q   <= '0;
            correct_q <= '0;
            mistake_q <= 1'b0;
            num_q     <= '0;
            letter_q  <= '0;
            repeat_q  <= 1'b0;
            invalid_q <= 1'b0;
            update_q  <= 1'b1;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                PLAY: begin
                    if (bus.guess_valid) begin
                        guess_q <= bus.guess;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    update_q  <= 1'b1;
                    letter_q  <= guess_q;
                    invalid_q <= !letter_ok;
                    repeat_q  <= already;
                    correct_q <= hit ? match_cnt : 3'd0;
                    mistake_q <= miss;
                    index_q   <= index_d;
                    num_q     <= num_d;
                    guessed_q <= guessed_d;
                    if (index_d == '1) begin
                        state_q <= WIN;
                        win_q   <= 1'b1;
                    end else if (num_d == 3'(MAX_MISTAKES)) begin
                        state_q <= LOSE;
                        lose_q  <= 1'b1;
                    end else begin
                        state_q <= PLAY;
                    end
                end
                IDLE, WIN, LOSE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.guess_ready  = (state_q == PLAY);
    assign bus.indexCorrect = index_q;
    assign bus.correct      = correct_q;
    assign bus.mistake      = mistake_q;
    assign bus.numMistake   = num_q;
    assign bus.letter       = letter_q;
    assign bus.repeat_guess = repeat_q;
    assign bus.invalid      = invalid_q;
    assign bus.update       = update_q;
    assign bus.game_win     = win_q;
    assign bus.game_lose    = lose_q;

endmodule

// File: tb/tb_hangman_guess_engine.sv
// Directed table-driven bench for hangman_guess_engine plus hand-written corner sequences.
module tb_hangman_guess_engine;
    import hangman_pkg::*;

    logic clk;
    logic nRst;
    int   checks;
    int   errs;

    hangman_guess_engine_if bus ();

    hangman_guess_engine dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [39:0] APPLE = 40'h4150504C45;

    typedef struct {
        bit          load;
        logic [7:0]  g;
        logic [4:0]  idx;
        logic [2:0]  cor;
        logic        mis;
        logic [2:0]  num;
        logic [7:0]  let_;
        logic        rep;
        logic        inv;
        logic        win;
        logic        lose;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit load, input logic [7:0] g, input logic [4:0] idx,
                       input logic [2:0] cor, input logic mis, input logic [2:0] num,
                       input logic [7:0] let_, input logic rep, input logic inv,
                       input logic win, input logic lose, input logic rdy);
        vec_t v;
        v.load = load; v.g = g; v.idx = idx; v.cor = cor; v.mis = mis; v.num = num;
        v.let_ = let_; v.rep = rep; v.inv = inv; v.win = win; v.lose = lose; v.rdy = rdy;
        vecs.push_back(v);
    endtask

    task automatic add_load();
        add(1'b1, 8'h00, 5'b00000, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Ends on the negedge right after the edge that latched the word.
    task automatic do_load(input logic [39:0] w);
        @(negedge clk);
        bus.word       = w;
        bus.word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.word_valid = 1'b0;
    endtask

    // Ends on the negedge after edge k+1, where results must be visible.
    task automatic do_guess(input logic [7:0] g, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.guess_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(bus.guess_ready), 64'd1);
        bus.guess       = g;
        bus.guess_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.guess_valid = 1'b0;
        chk({tag, "_check_upd"}, 64'(bus.update), 64'd0);
        chk({tag, "_check_rdy"}, 64'(bus.guess_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_status(input vec_t v, input string tag);
        chk({tag, "_update"},  64'(bus.update),       64'd1);
        chk({tag, "_index"},   64'(bus.indexCorrect), 64'(v.idx));
        chk({tag, "_correct"}, 64'(bus.correct),      64'(v.cor));
        chk({tag, "_mistake"}, 64'(bus.mistake),      64'(v.mis));
        chk({tag, "_num"},     64'(bus.numMistake),   64'(v.num));
        chk({tag, "_letter"},  64'(bus.letter),       64'(v.let_));
        chk({tag, "_repeat"},  64'(bus.repeat_guess), 64'(v.rep));
        chk({tag, "_invalid"}, 64'(bus.invalid),      64'(v.inv));
        chk({tag, "_win"},     64'(bus.game_win),     64'(v.win));
        chk({tag, "_lose"},    64'(bus.game_lose),    64'(v.lose));
        chk({tag, "_ready"},   64'(bus.guess_ready),  64'(v.rdy));
    endtask

    // After a game ends, offered guesses must be ignored and status frozen.
    task automatic ignore_guess(input vec_t v, input string tag);
        bus.guess       = 8'h5A;
        bus.guess_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk({tag, "_frozen_upd"}, 64'(bus.update), 64'd0);
            chk({tag, "_frozen_rdy"}, 64'(bus.guess_ready), 64'd0);
        end
        bus.guess_valid = 1'b0;
        chk({tag, "_frozen_letter"}, 64'(bus.letter), 64'(v.let_));
        chk({tag, "_frozen_index"},  64'(bus.indexCorrect), 64'(v.idx));
        chk({tag, "_frozen_win"},    64'(bus.game_win), 64'(v.win));
        chk({tag, "_frozen_lose"},   64'(bus.game_lose), 64'(v.lose));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string tag;
        checks = 0;
        errs   = 0;
        nRst            = 1'b0;
        bus.word        = '0;
        bus.word_valid  = 1'b0;
        bus.guess       = '0;
        bus.guess_valid = 1'b0;

        // Basic game on APPLE: miss, hit with duplicate, repeat, invalid.
        add_load();
        add(0, 8'h42, 5'b00000, 3'd0, 1, 3'd1, 8'h42, 0, 0, 0, 0, 1);
        add(0, 8'h50, 5'b01100, 3'd2, 0, 3'd1, 8'h50, 0, 0, 0, 0, 1);
        add(0, 8'h50, 5'b01100, 3'd0, 0, 3'd1, 8'h50, 1, 0, 0, 0, 1);
        add(0, 8'h0A, 5'b01100, 3'd0, 0, 3'd1, 8'h0A, 0, 1, 0, 0, 1);
        // Winning game.
        add_load();
        add(0, 8'h41, 5'b10000, 3'd1, 0, 3'd0, 8'h41, 0, 0, 0, 0, 1);
        add(0, 8'h50, 5'b11100, 3'd2, 0, 3'd0, 8'h50, 0, 0, 0, 0, 1);
        add(0, 8'h4C, 5'b11110, 3'd1, 0, 3'd0, 8'h4C, 0, 0, 0, 0, 1);
        add(0, 8'h45, 5'b11111, 3'd1, 0, 3'd0, 8'h45, 0, 0, 1, 0, 0);
        // Losing game, then a fresh word clears everything.
        add_load();
        add(0, 8'h42, 5'b00000, 3'd0, 1, 3'd1, 8'h42, 0, 0, 0, 0, 1);
        add(0, 8'h43, 5'b00000, 3'd0, 1, 3'd2, 8'h43, 0, 0, 0, 0, 1);
        add(0, 8'h44, 5'b00000, 3'd0, 1, 3'd3, 8'h44, 0, 0, 0, 0, 1);
        add(0, 8'h46, 5'b00000, 3'd0, 1, 3'd4, 8'h46, 0, 0, 0, 0, 1);
        add(0, 8'h47, 5'b00000, 3'd0, 1, 3'd5, 8'h47, 0, 0, 0, 0, 1);
        add(0, 8'h48, 5'b00000, 3'd0, 1, 3'd6, 8'h48, 0, 0, 0, 1, 0);
        add_load();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_index",  64'(bus.indexCorrect), 64'd0);
        chk("rst_num",    64'(bus.numMistake),   64'd0);
        chk("rst_letter", 64'(bus.letter),       64'd0);
        chk("rst_update", 64'(bus.update),       64'd0);
        chk("rst_ready",  64'(bus.guess_ready),  64'd0);
        chk("rst_flags",  64'({bus.mistake, bus.repeat_guess, bus.invalid,
                               bus.game_win, bus.game_lose, bus.correct}), 64'd0);
        nRst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(bus.guess_ready), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("v%0d", i);
            if (vecs[i].load) do_load(APPLE);
            else              do_guess(vecs[i].g, tag);
            check_status(vecs[i], tag);
            @(negedge clk);
            chk({tag, "_pulse_end"}, 64'(bus.update), 64'd0);
            if (vecs[i].win || vecs[i].lose) ignore_guess(vecs[i], tag);
        end

        // word_valid and guess_valid together: the word wins, the guess is dropped.
        @(negedge clk);
        bus.word        = APPLE;
        bus.word_valid  = 1'b1;
        bus.guess       = 8'h42;
        bus.guess_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.word_valid  = 1'b0;
        bus.guess_valid = 1'b0;
        chk("both_update", 64'(bus.update), 64'd1);
        chk("both_ready",  64'(bus.guess_ready), 64'd1);
        chk("both_letter", 64'(bus.letter), 64'd0);
        @(negedge clk);
        chk("both_noacc_upd", 64'(bus.update), 64'd0);
        chk("both_noacc_rdy", 64'(bus.guess_ready), 64'd1);
        repeat (2) @(negedge clk);
        chk("both_num", 64'(bus.numMistake), 64'd0);

        // Reset asserted while in CHECK.
        do_guess(8'h42, "pre_rst");
        chk("pre_rst_num", 64'(bus.numMistake), 64'd1);
        @(negedge clk);
        bus.guess       = 8'h43;
        bus.guess_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.guess_valid = 1'b0;
        nRst = 1'b0;
        #1;
        chk("midrst_num",    64'(bus.numMistake), 64'd0);
        chk("midrst_letter", 64'(bus.letter),     64'd0);
        chk("midrst_update", 64'(bus.update),     64'd0);
        chk("midrst_ready",  64'(bus.guess_ready), 64'd0);
        chk("midrst_mis",    64'(bus.mistake),    64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_upd2", 64'(bus.update), 64'd0);
        nRst = 1'b1;
        @(negedge clk);
        chk("post_rst_update", 64'(bus.update), 64'd0);
        chk("post_rst_ready",  64'(bus.guess_ready), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
